// File: rtl/emmc_blk_buf_pkg.sv
// Shared types and constants for the eMMC block buffer front end.
// BLK_CNT_WIDTH mirrors the block-count width used by the eMMC block state machine.
package emmc_blk_buf_p;

    localparam int BLK_CNT_WIDTH = 16;
    localparam int BLK_BYTES     = 512;
    localparam int BLK_SHIFT     = $clog2(BLK_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SPACE,
        START,
        BUSY,
        DONE
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/emmc_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with flush.
// Pointers carry one extra wrap bit so count is a plain subtraction.
module emmc_byte_fifo #(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [7:0]  data_i,
    input  logic        pop_i,
    output logic [7:0]  data_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        push_ok, pop_ok;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/emmc_blk_buf.sv
// emmc_blk_buf: buffers user request/byte streams and drives the eMMC block SM strobes.
// Optional build macro EMMC_BLK_BUF_STATS_EN adds xfer_cnt_o/byte_cnt_o counters.
module emmc_blk_buf
    import emmc_blk_buf_p::*;
#(
    parameter int  DEPTH    = 1024,
    parameter int  BUSY_TMO = 2**20,
    localparam int BCW      = BLK_CNT_WIDTH
) (
    input  logic           clk_i,
    input  logic           arst_ni,
    // Every stream transfers on the cycle where its valid and ready are both high;
    // valid never waits on ready, and ready may depend combinationally on state only.
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic           req_we_i,
    input  logic [BCW-1:0] req_blk_cnt_i,
    input  logic           wr_valid_i,
    input  logic [7:0]     wr_data_i,
    output logic           wr_ready_o,
    output logic           rd_valid_o,
    output logic [7:0]     rd_data_o,
    input  logic           rd_ready_i,
    output logic           sm_we_o,
    output logic           sm_start_o,
    output logic [BCW-1:0] sm_blk_cnt_o,
    output logic [7:0]     sm_dat_o,
    input  logic [7:0]     sm_dat_i,
    input  logic           sm_dvalid_i,
    input  logic           sm_ready_i,
    output logic           busy_o,
    output logic           err_ovf_o,
    output logic           err_unf_o,
    output logic           err_tmo_o,
    input  logic           err_clr_i,
`ifdef EMMC_BLK_BUF_STATS_EN
    output logic [31:0]    xfer_cnt_o,
    output logic [31:0]    byte_cnt_o,
`endif
    output state_t         state_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          NW      = BCW + BLK_SHIFT;
    localparam int          TW      = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] BLK_C   = (AW+1)'(BLK_BYTES);

    state_t         state_q, state_d;
    logic           we_q, seen_low_q, rst_done_q;
    logic [BCW-1:0] blk_cnt_q;
    logic [TW-1:0]  tmo_cnt_q;
    logic           err_ovf_q, err_unf_q, err_tmo_q;

    logic [7:0]     fifo_head, fifo_wdata;
    logic [AW:0]    fifo_count, fifo_free, space_need;
    logic           fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [NW-1:0]  bytes_req;
    logic           in_xfer, req_fire, sm_push, sm_pop, user_push, user_pop;
    logic           set_ovf, set_unf, set_tmo, busy_done, tmo_hit;

    assign in_xfer     = (state_q != IDLE);
    assign req_ready_o = (state_q == IDLE) && rst_done_q;
    assign req_fire    = req_valid_i && req_ready_o;
    assign wr_ready_o  = !fifo_full && ((state_q == IDLE) || we_q);
    assign user_push   = wr_valid_i && wr_ready_o;
    assign user_pop    = rd_ready_i && !fifo_empty;

    // The SM strobe cannot stall: it pops on writes and pushes on reads.
    assign sm_push    = sm_dvalid_i && in_xfer && !we_q;
    assign sm_pop     = sm_dvalid_i && in_xfer && we_q;
    assign fifo_push  = user_push || sm_push;
    assign fifo_wdata = sm_push ? sm_dat_i : wr_data_i;
    assign fifo_pop   = user_pop || sm_pop;
    assign set_ovf    = sm_push && fifo_full && !user_pop;
    assign set_unf    = sm_pop && fifo_empty;

    // A read larger than the FIFO starts once the whole FIFO is free.
    assign fifo_free  = DEPTH_C - fifo_count;
    assign bytes_req  = {blk_cnt_q, {BLK_SHIFT{1'b0}}};
    assign space_need = (bytes_req >= NW'(DEPTH)) ? DEPTH_C : bytes_req[AW:0];

    assign busy_done  = (state_q == BUSY) && seen_low_q && sm_ready_i;
    assign tmo_hit    = (BUSY_TMO != 0) && (state_q == BUSY)
                        && (tmo_cnt_q == TW'(BUSY_TMO - 1));
    assign set_tmo    = tmo_hit && !busy_done;
    assign fifo_flush = set_tmo;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_fire && (req_blk_cnt_i != '0)) state_d = req_we_i ? FILL : SPACE;
            FILL:  if ((fifo_count >= BLK_C) && sm_ready_i) state_d = START;
            SPACE: if ((fifo_free >= space_need) && sm_ready_i) state_d = START;
            START: state_d = BUSY;
            BUSY:  begin
                if (busy_done)    state_d = DONE;
                else if (tmo_hit) state_d = IDLE;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            blk_cnt_q  <= '0;
            seen_low_q <= 1'b0;
            tmo_cnt_q  <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (req_fire) begin
                we_q      <= req_we_i;
                blk_cnt_q <= req_blk_cnt_i;
            end
            // BUSY completes only after the SM has left and re-entered its idle state.
            seen_low_q <= (state_q == BUSY) && (seen_low_q || !sm_ready_i);
            tmo_cnt_q  <= (state_q == BUSY) ? tmo_cnt_q + TW'(1) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            err_ovf_q <= set_ovf || (err_ovf_q && !err_clr_i);
            err_unf_q <= set_unf || (err_unf_q && !err_clr_i);
            err_tmo_q <= set_tmo || (err_tmo_q && !err_clr_i);
        end
    end

`ifdef EMMC_BLK_BUF_STATS_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            xfer_cnt_o <= '0;
            byte_cnt_o <= '0;
        end else begin
            if (state_q == DONE)         xfer_cnt_o <= sat_inc(xfer_cnt_o);
            if (sm_dvalid_i && in_xfer) byte_cnt_o <= sat_inc(byte_cnt_o);
        end
    end
`endif

    emmc_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sm_we_o      = we_q;
    assign sm_start_o   = (state_q == START);
    assign sm_blk_cnt_o = blk_cnt_q;
    assign sm_dat_o     = fifo_empty ? 8'h00 : fifo_head;
    assign rd_valid_o   = !fifo_empty;
    assign rd_data_o    = fifo_empty ? 8'h00 : fifo_head;
    assign busy_o       = in_xfer;
    assign err_ovf_o    = err_ovf_q;
    assign err_unf_o    = err_unf_q;
    assign err_tmo_o    = err_tmo_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_emmc_blk_buf.sv
// Directed bench for emmc_blk_buf; the bench itself plays the eMMC block SM.
// A second instance with a 64-cycle watchdog is held in reset except for the timeout case.
`timescale 1ns/1ps
module tb_emmc_blk_buf;
    import emmc_blk_buf_p::*;

    localparam int BCW = BLK_CNT_WIDTH;

    logic           clk_i = 1'b0;
    logic           arst_ni = 1'b0;
    logic           t_arst_ni = 1'b0;
    logic           req_valid_i = 1'b0, req_we_i = 1'b0;
    logic [BCW-1:0] req_blk_cnt_i = '0;
    logic           wr_valid_i = 1'b0;
    logic [7:0]     wr_data_i = 8'h00;
    logic           rd_ready_i = 1'b0;
    logic [7:0]     sm_dat_i = 8'h00;
    logic           sm_dvalid_i = 1'b0, sm_ready_i = 1'b1, err_clr_i = 1'b0;

    logic           req_ready_o, wr_ready_o, rd_valid_o, sm_we_o, sm_start_o;
    logic [7:0]     rd_data_o, sm_dat_o;
    logic [BCW-1:0] sm_blk_cnt_o;
    logic           busy_o, err_ovf_o, err_unf_o, err_tmo_o;
    state_t         state_o;

    logic           t_req_ready_o, t_wr_ready_o, t_rd_valid_o, t_sm_we_o, t_sm_start_o;
    logic [7:0]     t_rd_data_o, t_sm_dat_o;
    logic [BCW-1:0] t_sm_blk_cnt_o;
    logic           t_busy_o, t_err_ovf_o, t_err_unf_o, t_err_tmo_o;
    state_t         t_state_o;

    logic [7:0]     exp_q[$];
    int             n_tests = 0;
    int             n_fail = 0;
    int             start_cnt = 0;
    int             start_snap;
    logic           rd_mon_en = 1'b0;

    emmc_blk_buf dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_blk_cnt_i(req_blk_cnt_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
        .sm_we_o(sm_we_o), .sm_start_o(sm_start_o), .sm_blk_cnt_o(sm_blk_cnt_o),
        .sm_dat_o(sm_dat_o), .sm_dat_i(sm_dat_i), .sm_dvalid_i(sm_dvalid_i),
        .sm_ready_i(sm_ready_i), .busy_o(busy_o),
        .err_ovf_o(err_ovf_o), .err_unf_o(err_unf_o), .err_tmo_o(err_tmo_o),
        .err_clr_i(err_clr_i), .state_o(state_o)
    );

    emmc_blk_buf #(.BUSY_TMO(64)) dut_tmo (
        .clk_i(clk_i), .arst_ni(t_arst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(t_req_ready_o), .req_we_i(req_we_i),
        .req_blk_cnt_i(req_blk_cnt_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(t_wr_ready_o),
        .rd_valid_o(t_rd_valid_o), .rd_data_o(t_rd_data_o), .rd_ready_i(rd_ready_i),
        .sm_we_o(t_sm_we_o), .sm_start_o(t_sm_start_o), .sm_blk_cnt_o(t_sm_blk_cnt_o),
        .sm_dat_o(t_sm_dat_o), .sm_dat_i(sm_dat_i), .sm_dvalid_i(sm_dvalid_i),
        .sm_ready_i(sm_ready_i), .busy_o(t_busy_o),
        .err_ovf_o(t_err_ovf_o), .err_unf_o(t_err_unf_o), .err_tmo_o(t_err_tmo_o),
        .err_clr_i(err_clr_i), .state_o(t_state_o)
    );

    // Clock and run-time guard
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the user read stream and start-pulse counter
    always @(negedge clk_i) begin
        if (sm_start_o) start_cnt++;
        if (rd_mon_en && rd_valid_o && rd_ready_i) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid_o), 32'd0);
            else check("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_req(input logic we, input logic [BCW-1:0] cnt, input string tag);
        req_valid_i = 1'b1;
        req_we_i = we;
        req_blk_cnt_i = cnt;
        check(tag, 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] b);
        wr_valid_i = 1'b1;
        wr_data_i = b;
        exp_q.push_back(b);
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!sm_start_o && n < 20);
        check(tag, 32'(sm_start_o), 32'd1);
    endtask

    task automatic sm_consume(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sm_dvalid_i = 1'b1;
            check(tag, 32'(sm_dat_o), 32'(exp_q.pop_front()));
            tick();
        end
        sm_dvalid_i = 1'b0;
    endtask

    task automatic sm_emit(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            sm_dvalid_i = 1'b1;
            sm_dat_i = 8'(i * 7 + seed);
            exp_q.push_back(sm_dat_i);
            tick();
        end
        sm_dvalid_i = 1'b0;
    endtask

    task automatic sm_finish(input logic [BCW-1:0] cnt, input string tag);
        sm_ready_i = 1'b1;
        tick();
        check({tag, "_done"}, 32'(state_o), 32'(DONE));
        check({tag, "_blkcnt"}, 32'(sm_blk_cnt_o), 32'(cnt));
        tick();
        check({tag, "_idle"}, 32'(state_o), 32'(IDLE));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rd_ready_i = 1'b1;
        rd_mon_en = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        rd_ready_i = 1'b0;
        rd_mon_en = 1'b0;
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({tag, "_empty"}, 32'(rd_valid_o), 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_wr_ready", 32'(wr_ready_o), 32'd1);
        check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check("rst_rd_data", 32'(rd_data_o), 32'd0);
        check("rst_outs", {24'd0, sm_we_o, sm_start_o, busy_o, err_ovf_o, err_unf_o, err_tmo_o, 2'b00}, 32'd0);
        check("rst_blk_cnt", 32'(sm_blk_cnt_o), 32'd0);
        check("rst_sm_dat", 32'(sm_dat_o), 32'd0);
        @(negedge clk_i) arst_ni = 1'b1;
        tick();

        // Zero block count is accepted and dropped
        send_req(1'b1, '0, "zero_req");
        tick();
        check("zero_state", 32'(state_o), 32'(IDLE));
        check("zero_no_start", 32'(start_cnt), 32'd0);

        // Write one block, pre-loaded
        for (int i = 0; i < 512; i++) push_wr(8'(i));
        send_req(1'b1, 16'd1, "wr1_req");
        wait_start("wr1_start");
        check("wr1_we", 32'(sm_we_o), 32'd1);
        sm_ready_i = 1'b0;
        sm_consume(512, "wr1_dat");
        sm_dvalid_i = 1'b1;
        check("unf_dat_zero", 32'(sm_dat_o), 32'd0);
        tick();
        sm_dvalid_i = 1'b0;
        check("unf_set", 32'(err_unf_o), 32'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("unf_clr", 32'(err_unf_o), 32'd0);
        sm_finish(16'd1, "wr1");
        check("wr1_one_start", 32'(start_cnt), 32'd1);

        // Write with 511 bytes waits; 512th releases start
        send_req(1'b1, 16'd1, "fill_req");
        for (int i = 0; i < 511; i++) push_wr(8'(255 - i));
        start_snap = start_cnt;
        repeat (4) tick();
        check("fill_hold", 32'(state_o), 32'(FILL));
        check("fill_no_start", 32'(start_cnt), 32'(start_snap));
        push_wr(8'h5A);
        tick();
        check("fill_start", 32'(sm_start_o), 32'd1);
        sm_ready_i = 1'b0;
        sm_consume(512, "fill_dat");
        sm_finish(16'd1, "fill");

        // Read two blocks with the user draining
        send_req(1'b0, 16'd2, "rd2_req");
        wait_start("rd2_start");
        check("rd2_we", 32'(sm_we_o), 32'd0);
        sm_ready_i = 1'b0;
        rd_ready_i = 1'b1;
        rd_mon_en = 1'b1;
        tick();
        check("rd2_wr_blocked", 32'(wr_ready_o), 32'd0);
        sm_emit(1024, 3);
        check("rd2_no_ovf", 32'(err_ovf_o), 32'd0);
        sm_finish(16'd2, "rd2");
        drain("rd2");

        // Read four blocks with no draining: overflow on byte 1025
        send_req(1'b0, 16'd4, "rd4_req");
        wait_start("rd4_start");
        sm_ready_i = 1'b0;
        sm_emit(1024, 11);
        check("rd4_full_no_ovf", 32'(err_ovf_o), 32'd0);
        sm_dvalid_i = 1'b1;
        sm_dat_i = 8'hEE;
        err_clr_i = 1'b1;
        tick();
        sm_dvalid_i = 1'b0;
        check("ovf_wins_clr", 32'(err_ovf_o), 32'd1);
        tick();
        err_clr_i = 1'b0;
        check("ovf_clr", 32'(err_ovf_o), 32'd0);
        sm_finish(16'd4, "rd4");
        drain("rd4");

        // Watchdog on the 64-cycle instance
        @(negedge clk_i) t_arst_ni = 1'b1;
        tick();
        check("tmo_req_ready", 32'(t_req_ready_o), 32'd1);
        send_req(1'b0, 16'd1, "tmo_req");
        wait_start("tmo_start");
        sm_ready_i = 1'b0;
        repeat (64) tick();
        check("tmo_busy64", 32'(t_state_o), 32'(BUSY));
        check("tmo_not_yet", 32'(t_err_tmo_o), 32'd0);
        tick();
        check("tmo_idle", 32'(t_state_o), 32'(IDLE));
        check("tmo_err", 32'(t_err_tmo_o), 32'd1);
        check("tmo_busy_o", 32'(t_busy_o), 32'd0);
        check("tmo_fifo", {24'd0, t_rd_valid_o, t_wr_ready_o, t_sm_start_o, t_sm_we_o,
                            t_err_ovf_o, t_err_unf_o, 2'b00}, 32'h40);
        check("tmo_heads", {16'd0, t_rd_data_o, t_sm_dat_o}, 32'd0);
        check("tmo_blkcnt", 32'(t_sm_blk_cnt_o), 32'd1);
        check("main_no_tmo", {30'd0, busy_o, err_tmo_o}, 32'd2);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("tmo_clr", 32'(t_err_tmo_o), 32'd0);
        sm_finish(16'd1, "tmo_main");
        t_arst_ni = 1'b0;

        // Reset in the middle of a read
        send_req(1'b0, 16'd1, "mid_req");
        wait_start("mid_start");
        sm_ready_i = 1'b0;
        sm_emit(300, 5);
        check("mid_has_data", 32'(rd_valid_o), 32'd1);
        #2 arst_ni = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_o), 32'(IDLE));
        check("mid_rst_outs", {24'd0, busy_o, rd_valid_o, wr_ready_o, sm_we_o, req_ready_o,
                                err_ovf_o, 2'b00}, 32'h20);
        check("mid_rst_blkcnt", 32'(sm_blk_cnt_o), 32'd0);
        exp_q.delete();
        sm_ready_i = 1'b1;
        @(negedge clk_i) arst_ni = 1'b1;
        tick();
        send_req(1'b1, 16'd1, "mid_new_req");
        check("mid_new_fill", 32'(state_o), 32'(FILL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
